// File: rtl/counter_nb.sv
// counter_nb: loadable up/down counter with cascade carry-in and registered
// ripple-carry/borrow and load-acknowledge pulses.
//
// Build option: define COUNTER_NB_SAT_EN to saturate instead of wrapping.
// Without the macro, every count mode wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH   counter width in bits (2..32)
//   STEP    decrement amount used by mode 10 (1..2^WIDTH-1)
//
// Ports
//   clk      single clock, rising edge
//   RESET_N  asynchronous active-low reset (clears Q, RCO, LOAD)
//   ENABLE   count/load enable
//   CIN      cascade carry-in, qualifies the count modes only
//   MODO     00 up, 01 down, 10 down-by-STEP, 11 load
//   D        parallel load data
//   Q        registered count value
//   RCO      registered ripple-carry/borrow pulse
//   LOAD     registered load-acknowledge pulse
//
// Cascading: the RCO of one stage drives the CIN of the next. Because RCO is
// registered, each stage sees the carry one edge after the lower stage wraps.

module counter_nb #(
    parameter int WIDTH = 8,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             CIN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             LOAD
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    // One extra bit on every result: bit WIDTH is the carry (up) or the
    // borrow (down) and doubles as the wrap/saturation flag.
    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] diff_one;
    logic [WIDTH:0] diff_step;

    logic [WIDTH-1:0] next_q;
    logic             next_rco;
    logic             next_load;

    assign sum_up    = {1'b0, Q} + ONE_X;
    assign diff_one  = {1'b0, Q} - ONE_X;
    assign diff_step = {1'b0, Q} - STEP_X;

    always_comb begin
        next_q    = Q;
        next_rco  = 1'b0;
        next_load = 1'b0;
        if (ENABLE) begin
            if (MODO == MODE_LOAD) begin
                next_q    = D;
                next_load = 1'b1;
            end else if (CIN) begin
                unique case (MODO)
                    MODE_UP: begin
                        next_rco = sum_up[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                        next_q   = sum_up[WIDTH] ? Q : sum_up[WIDTH-1:0];
`else
                        next_q   = sum_up[WIDTH-1:0];
`endif
                    end
                    MODE_DOWN: begin
                        next_rco = diff_one[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                        next_q   = diff_one[WIDTH] ? '0 : diff_one[WIDTH-1:0];
`else
                        next_q   = diff_one[WIDTH-1:0];
`endif
                    end
                    MODE_STEP: begin
                        next_rco = diff_step[WIDTH];
`ifdef COUNTER_NB_SAT_EN
                        next_q   = diff_step[WIDTH] ? '0 : diff_step[WIDTH-1:0];
`else
                        next_q   = diff_step[WIDTH-1:0];
`endif
                    end
                    default: begin
                        next_q   = Q;
                        next_rco = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            Q    <= '0;
            RCO  <= 1'b0;
            LOAD <= 1'b0;
        end else begin
            Q    <= next_q;
            RCO  <= next_rco;
            LOAD <= next_load;
        end
    end

endmodule

// File: tb/tb_counter_nb.sv
module tb_counter_nb;

    logic       clk;
    logic       RESET_N;
    logic       ENABLE, CIN;
    logic [1:0] MODO;
    logic [7:0] D;
    logic [7:0] Q;
    logic       RCO, LOAD;

    // cascade pair: low stage RCO feeds high stage CIN
    logic        c_en, c_cin;
    logic [1:0]  c_mode;
    logic [15:0] c_d;
    logic [7:0]  lo_q, hi_q;
    logic        lo_rco, hi_rco, lo_load, hi_load;

    counter_nb #(.WIDTH(8), .STEP(3)) dut (
        .clk(clk), .RESET_N(RESET_N), .ENABLE(ENABLE), .CIN(CIN),
        .MODO(MODO), .D(D), .Q(Q), .RCO(RCO), .LOAD(LOAD));

    counter_nb #(.WIDTH(8), .STEP(3)) u_lo (
        .clk(clk), .RESET_N(RESET_N), .ENABLE(c_en), .CIN(c_cin),
        .MODO(c_mode), .D(c_d[7:0]), .Q(lo_q), .RCO(lo_rco), .LOAD(lo_load));

    counter_nb #(.WIDTH(8), .STEP(3)) u_hi (
        .clk(clk), .RESET_N(RESET_N), .ENABLE(c_en), .CIN(lo_rco),
        .MODO(c_mode), .D(c_d[15:8]), .Q(hi_q), .RCO(hi_rco), .LOAD(hi_load));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;      // 0: single counter, 1: cascade pair
        logic [15:0] q;
        logic        rco;
        logic        load;
        logic        lo_rco;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // monitor: outputs settle after the rising edge; sample on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel) begin
                check({e.name, ".q"},    {8'h00, Q},    e.q);
                check({e.name, ".rco"},  {15'h0, RCO},  {15'h0, e.rco});
                check({e.name, ".load"}, {15'h0, LOAD}, {15'h0, e.load});
            end else begin
                check({e.name, ".q"},      {hi_q, lo_q},     e.q);
                check({e.name, ".hi_rco"}, {15'h0, hi_rco},  {15'h0, e.rco});
                check({e.name, ".hi_load"},{15'h0, hi_load}, {15'h0, e.load});
                check({e.name, ".lo_rco"}, {15'h0, lo_rco},  {15'h0, e.lo_rco});
            end
        end
    end

    task automatic step(input string nm, input logic en, input logic cin,
                        input logic [1:0] mode, input logic [7:0] d,
                        input logic [7:0] eq, input logic erco, input logic eload);
        exp_t e;
        @(negedge clk);
        #1;
        ENABLE = en; CIN = cin; MODO = mode; D = d;
        e.name = nm; e.sel = 1'b0; e.q = {8'h00, eq};
        e.rco = erco; e.load = eload; e.lo_rco = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic cstep(input string nm, input logic en, input logic cin,
                         input logic [1:0] mode, input logic [15:0] d,
                         input logic [15:0] eq, input logic erco, input logic eload,
                         input logic elo_rco);
        exp_t e;
        @(negedge clk);
        #1;
        ENABLE = 1'b0;
        c_en = en; c_cin = cin; c_mode = mode; c_d = d;
        e.name = nm; e.sel = 1'b1; e.q = eq;
        e.rco = erco; e.load = eload; e.lo_rco = elo_rco;
        exp_q.push_back(e);
    endtask

    initial begin
        RESET_N = 1'b0;
        ENABLE = 1'b0; CIN = 1'b0; MODO = 2'b00; D = 8'h00;
        c_en = 1'b0; c_cin = 1'b0; c_mode = 2'b00; c_d = 16'h0000;
        #2;
        check("reset.q",    {8'h00, Q}, 16'h0000);
        check("reset.flag", {14'h0, RCO, LOAD}, 16'h0000);
        @(negedge clk);
        RESET_N = 1'b1;

        // reach 0x5A, then reset asynchronously mid-count
        step("ld58",  1, 0, 2'b11, 8'h58, 8'h58, 0, 1);
        step("up59",  1, 1, 2'b00, 8'h00, 8'h59, 0, 0);
        step("up5a",  1, 1, 2'b00, 8'h00, 8'h5A, 0, 0);
        @(negedge clk);
        #1;
        ENABLE = 1'b1; CIN = 1'b1; MODO = 2'b00;
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst.q",    {8'h00, Q}, 16'h0000);
        check("async_rst.flag", {14'h0, RCO, LOAD}, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_hold.q", {8'h00, Q}, 16'h0000);
        @(negedge clk);
        ENABLE = 1'b0;
        RESET_N = 1'b1;
        step("rst_first_up", 1, 1, 2'b00, 8'h00, 8'h01, 0, 0);

        // load and up-count wrap
        step("ldfe",  1, 0, 2'b11, 8'hFE, 8'hFE, 0, 1);
        step("upff",  1, 1, 2'b00, 8'h00, 8'hFF, 0, 0);
`ifdef COUNTER_NB_SAT_EN
        step("upwrap", 1, 1, 2'b00, 8'h00, 8'hFF, 1, 0);
        step("upsat2", 1, 1, 2'b00, 8'h00, 8'hFF, 1, 0);
`else
        step("upwrap", 1, 1, 2'b00, 8'h00, 8'h00, 1, 0);
        step("up01",   1, 1, 2'b00, 8'h00, 8'h01, 0, 0);
`endif

        // step-down wrap
        step("ld04",  1, 1, 2'b11, 8'h04, 8'h04, 0, 1);
        step("st01",  1, 1, 2'b10, 8'h00, 8'h01, 0, 0);
`ifdef COUNTER_NB_SAT_EN
        step("stwrap", 1, 1, 2'b10, 8'h00, 8'h00, 1, 0);
`else
        step("stwrap", 1, 1, 2'b10, 8'h00, 8'hFE, 1, 0);
        step("stfb",   1, 1, 2'b10, 8'h00, 8'hFB, 0, 0);
`endif

        // down-count from zero
        step("ld00",  1, 0, 2'b11, 8'h00, 8'h00, 0, 1);
`ifdef COUNTER_NB_SAT_EN
        step("dnwrap", 1, 1, 2'b01, 8'h00, 8'h00, 1, 0);
        step("dn2",    1, 1, 2'b01, 8'h00, 8'h00, 1, 0);
`else
        step("dnwrap", 1, 1, 2'b01, 8'h00, 8'hFF, 1, 0);
        step("dnfe",   1, 1, 2'b01, 8'h00, 8'hFE, 0, 0);
`endif

        // hold cases
        step("ld37",  1, 0, 2'b11, 8'h37, 8'h37, 0, 1);
        for (int i = 0; i < 5; i++)
            step("hold_en0", 0, 1, 2'b00, 8'hAA, 8'h37, 0, 0);
        step("hold_en0_ld", 0, 1, 2'b11, 8'hAA, 8'h37, 0, 0);
        step("hold_cin0a",  1, 0, 2'b01, 8'h00, 8'h37, 0, 0);
        step("hold_cin0b",  1, 0, 2'b01, 8'h00, 8'h37, 0, 0);

        // immediate mode changes
        step("dn36",  1, 1, 2'b01, 8'h00, 8'h36, 0, 0);
        step("up37",  1, 1, 2'b00, 8'h00, 8'h37, 0, 0);
        step("ld_a5", 1, 0, 2'b11, 8'hA5, 8'hA5, 0, 1);
        step("st_a2", 1, 1, 2'b10, 8'h00, 8'hA2, 0, 0);
        step("idle",  0, 0, 2'b00, 8'h00, 8'hA2, 0, 0);

        // cascade: the registered low RCO reaches the high stage one edge
        // after the low stage wraps, so low CIN is dropped on that edge
        cstep("c_ld00ff", 1, 0, 2'b11, 16'h00FF, 16'h00FF, 0, 1, 0);
`ifdef COUNTER_NB_SAT_EN
        cstep("c_wrap",   1, 1, 2'b00, 16'h0000, 16'h00FF, 0, 0, 1);
        cstep("c_carry",  1, 0, 2'b00, 16'h0000, 16'h01FF, 0, 0, 0);
`else
        cstep("c_wrap",   1, 1, 2'b00, 16'h0000, 16'h0000, 0, 0, 1);
        cstep("c_carry",  1, 0, 2'b00, 16'h0000, 16'h0100, 0, 0, 0);
`endif
        cstep("c_idle",   0, 0, 2'b00, 16'h0000, 16'h0100
`ifdef COUNTER_NB_SAT_EN
              | 16'h00FF
`endif
              , 0, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d items left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
